// File: rtl/sprite_anim_pkg.sv
// Shared types and screen constants for the sprite animation sequencer and its address generator.
package sprite_anim_pkg;

  typedef enum logic [1:0] {
    LOOP     = 2'd0,
    PINGPONG = 2'd1,
    ONESHOT  = 2'd2
  } anim_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  // One bit wider than the screen so PlayerX+SPRITE_W-1 never wraps past the right/bottom edge.
  localparam int CMP_W = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H) + 1;

endpackage

// File: rtl/sprite_addr_gen.sv
// Window compare, frame-boundary bank/frame latch and registered sprite-ROM address.
// SPRITE_MIRROR_EN: left-facing pixels read the right bank with the column mirrored.
module sprite_addr_gen
  import sprite_anim_pkg::*;
#(
  parameter int SPRITE_W     = 40,
  parameter int SPRITE_H     = 40,
  parameter int RIGHT_OFFSET = 0,
  parameter int LEFT_OFFSET  = 6400,
  parameter int ADDR_W       = 21
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        frame_i,
  input  logic              dir_i,
  input  logic [9:0]        draw_x_i,
  input  logic [9:0]        draw_y_i,
  input  logic [9:0]        player_x_i,
  input  logic [9:0]        player_y_i,
  output logic              on_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [3:0]        disp_frame_q;
  logic              disp_dir_q;
  logic              on_q;
  logic [ADDR_W-1:0] addr_q;

  logic [CMP_W-1:0]  dx, dy, px, py, col, row;
  logic [ADDR_W-1:0] base, addr_d;
  logic              on_d;

  always_comb begin
    dx  = CMP_W'(draw_x_i);
    dy  = CMP_W'(draw_y_i);
    px  = CMP_W'(player_x_i);
    py  = CMP_W'(player_y_i);
    col = dx - px;
    row = dy - py;
`ifdef SPRITE_MIRROR_EN
    if (disp_dir_q) col = CMP_W'(SPRITE_W - 1) - col;
    base = ADDR_W'(RIGHT_OFFSET);
`else
    base = disp_dir_q ? ADDR_W'(LEFT_OFFSET) : ADDR_W'(RIGHT_OFFSET);
`endif
    on_d = (dx >= px) && (dx <= px + CMP_W'(SPRITE_W - 1)) &&
           (dy >= py) && (dy <= py + CMP_W'(SPRITE_H - 1));
    addr_d = '0;
    if (on_d)
      addr_d = base + ADDR_W'(disp_frame_q) * ADDR_W'(SPRITE_W * SPRITE_H)
             + ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
  end

  // Bank and frame only change at the top-left pixel so a frame is never drawn half-and-half.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disp_frame_q <= '0;
      disp_dir_q   <= 1'b0;
      on_q         <= 1'b0;
      addr_q       <= '0;
    end else begin
      if (draw_x_i == 10'd0 && draw_y_i == 10'd0) begin
        disp_frame_q <= frame_i;
        disp_dir_q   <= dir_i;
      end
      on_q   <= on_d;
      addr_q <= addr_d;
    end
  end

  assign on_o   = on_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Frame sequencer (LOOP / PINGPONG / ONESHOT) driving a sprite-ROM address generator.
// Optional macro SPRITE_MIRROR_EN is handled inside sprite_addr_gen.
module sprite_anim_sequencer
  import sprite_anim_pkg::*;
#(
  parameter int FRAME_COUNT  = 4,
  parameter int HOLD_TICKS   = 4,
  parameter int SPRITE_W     = 40,
  parameter int SPRITE_H     = 40,
  parameter int RIGHT_OFFSET = 0,
  parameter int LEFT_OFFSET  = 6400,
  parameter int MODE         = 1,
  parameter int ADDR_W       = 21
) (
  input  logic              frame_Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              moving,
  input  logic              trigger,
  input  logic              playerDirection,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        PlayerX,
  input  logic [9:0]        PlayerY,
  output logic              playerOn,
  output logic [ADDR_W-1:0] spriteAddress,
  output logic [3:0]        frameIndex,
  output logic              anim_done
);

  localparam anim_mode_t MODE_E    = anim_mode_t'(MODE);
  localparam logic [3:0] LAST      = 4'(FRAME_COUNT - 1);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);

  seq_state_t state_q;
  logic [3:0] frame_q;
  logic [3:0] hold_q;
  logic       done_q;

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else if (MODE_E == ONESHOT) begin
      if (trigger && (state_q == IDLE || state_q == DONE)) begin
        state_q <= FWD;
        frame_q <= '0;
        hold_q  <= '0;
        done_q  <= 1'b0;
      end else if (frame_tick && state_q == FWD) begin
        if (hold_q != HOLD_LAST) begin
          hold_q <= hold_q + 4'd1;
        end else begin
          hold_q <= '0;
          if (frame_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            frame_q <= frame_q + 4'd1;
          end
        end
      end
    end else if (!moving) begin
      state_q <= IDLE;
      frame_q <= '0;
      hold_q  <= '0;
    end else if (state_q == IDLE) begin
      state_q <= FWD;
      frame_q <= '0;
      hold_q  <= '0;
    end else if (frame_tick) begin
      if (hold_q != HOLD_LAST) begin
        hold_q <= hold_q + 4'd1;
      end else begin
        hold_q <= '0;
        if (MODE_E == LOOP) begin
          frame_q <= (frame_q == LAST) ? 4'd0 : frame_q + 4'd1;
        end else if (LAST == 4'd0) begin
          frame_q <= '0;
        end else if (state_q == FWD) begin
          if (frame_q == LAST) begin
            frame_q <= frame_q - 4'd1;
            state_q <= REV;
          end else begin
            frame_q <= frame_q + 4'd1;
          end
        end else begin
          if (frame_q == 4'd0) begin
            frame_q <= 4'd1;
            state_q <= FWD;
          end else begin
            frame_q <= frame_q - 4'd1;
          end
        end
      end
    end
  end

  assign frameIndex = frame_q;
  assign anim_done  = done_q;

  sprite_addr_gen #(
    .SPRITE_W    (SPRITE_W),
    .SPRITE_H    (SPRITE_H),
    .RIGHT_OFFSET(RIGHT_OFFSET),
    .LEFT_OFFSET (LEFT_OFFSET),
    .ADDR_W      (ADDR_W)
  ) u_addr (
    .clk_i     (frame_Clk),
    .rst_i     (Reset),
    .frame_i   (frame_q),
    .dir_i     (playerDirection),
    .draw_x_i  (DrawX),
    .draw_y_i  (DrawY),
    .player_x_i(PlayerX),
    .player_y_i(PlayerY),
    .on_o      (playerOn),
    .addr_o    (spriteAddress)
  );

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed bench: three sequencer configurations (PINGPONG, LOOP hold 4, ONESHOT N=3) on shared stimulus.
module tb_sprite_anim_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick, moving, trigger, dir;
  logic [9:0] draw_x, draw_y, player_x, player_y;

  logic        pp_on, lp_on, os_on;
  logic [20:0] pp_addr, lp_addr, os_addr;
  logic [3:0]  pp_frame, lp_frame, os_frame;
  logic        pp_done, lp_done, os_done;

  int errors = 0;
  int checks = 0;

  sprite_anim_sequencer #(.FRAME_COUNT(4), .HOLD_TICKS(1), .MODE(1)) u_pp (
    .frame_Clk(clk), .Reset(rst), .frame_tick(tick), .moving(moving), .trigger(trigger),
    .playerDirection(dir), .DrawX(draw_x), .DrawY(draw_y), .PlayerX(player_x), .PlayerY(player_y),
    .playerOn(pp_on), .spriteAddress(pp_addr), .frameIndex(pp_frame), .anim_done(pp_done));

  sprite_anim_sequencer #(.FRAME_COUNT(4), .HOLD_TICKS(4), .MODE(0)) u_lp (
    .frame_Clk(clk), .Reset(rst), .frame_tick(tick), .moving(moving), .trigger(trigger),
    .playerDirection(dir), .DrawX(draw_x), .DrawY(draw_y), .PlayerX(player_x), .PlayerY(player_y),
    .playerOn(lp_on), .spriteAddress(lp_addr), .frameIndex(lp_frame), .anim_done(lp_done));

  sprite_anim_sequencer #(.FRAME_COUNT(3), .HOLD_TICKS(1), .MODE(2)) u_os (
    .frame_Clk(clk), .Reset(rst), .frame_tick(tick), .moving(moving), .trigger(trigger),
    .playerDirection(dir), .DrawX(draw_x), .DrawY(draw_y), .PlayerX(player_x), .PlayerY(player_y),
    .playerOn(os_on), .spriteAddress(os_addr), .frameIndex(os_frame), .anim_done(os_done));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; moving = 1'b0; trigger = 1'b0; dir = 1'b0;
    draw_x = 10'd300; draw_y = 10'd300; player_x = 10'd500; player_y = 10'd400;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; moving = 1'b1; trigger = 1'b1; dir = 1'b1;
    draw_x = 10'd5; draw_y = 10'd5; player_x = 10'd0; player_y = 10'd0;
    step(); step();
    checks++; if (pp_frame !== 4'd0) begin errors++; $display("FAIL reset_pp_frame got=%0d exp=0", pp_frame); end
    checks++; if (lp_frame !== 4'd0) begin errors++; $display("FAIL reset_lp_frame got=%0d exp=0", lp_frame); end
    checks++; if (os_frame !== 4'd0) begin errors++; $display("FAIL reset_os_frame got=%0d exp=0", os_frame); end
    checks++; if (os_done !== 1'b0) begin errors++; $display("FAIL reset_os_done got=%0b exp=0", os_done); end
    checks++; if (pp_on !== 1'b0) begin errors++; $display("FAIL reset_playerOn got=%0b exp=0", pp_on); end
    checks++; if (pp_addr !== 21'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", pp_addr); end
    rst = 1'b0;
  endtask

  task automatic test_pingpong();
    logic [3:0] exp_seq [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1};
    do_reset();
    moving = 1'b1; tick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (pp_frame !== exp_seq[i]) begin
        errors++; $display("FAIL pingpong_step%0d got=%0d exp=%0d", i, pp_frame, exp_seq[i]);
      end
    end
  endtask

  task automatic test_loop_hold();
    logic [3:0] exp;
    do_reset();
    moving = 1'b1; tick = 1'b0;
    step();
    tick = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp = 4'(((i / 4) % 4));
      checks++;
      if (lp_frame !== exp) begin
        errors++; $display("FAIL loop_tick%0d got=%0d exp=%0d", i, lp_frame, exp);
      end
    end
    tick = 1'b0;
    step();
    checks++; if (lp_frame !== 4'd1) begin errors++; $display("FAIL loop_no_tick_hold got=%0d exp=1", lp_frame); end
    moving = 1'b0; tick = 1'b1;
    step();
    checks++; if (lp_frame !== 4'd0) begin errors++; $display("FAIL loop_stop_priority got=%0d exp=0", lp_frame); end
    moving = 1'b1; tick = 1'b0;
    step();
    tick = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = (i == 4) ? 4'd1 : 4'd0;
      checks++;
      if (lp_frame !== exp) begin
        errors++; $display("FAIL loop_restart_tick%0d got=%0d exp=%0d", i, lp_frame, exp);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [3:0] exp_f [6] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd0};
    logic       exp_d [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       trg   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    moving = 1'b0; tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      trigger = trg[i];
      step();
      checks++;
      if (os_frame !== exp_f[i]) begin
        errors++; $display("FAIL oneshot_frame%0d got=%0d exp=%0d", i, os_frame, exp_f[i]);
      end
      checks++;
      if (os_done !== exp_d[i]) begin
        errors++; $display("FAIL oneshot_done%0d got=%0b exp=%0b", i, os_done, exp_d[i]);
      end
    end
    trigger = 1'b0;
  endtask

  task automatic test_window_addr();
    logic [20:0] exp_left, exp_edge_r, exp_edge_b, exp_col0;
`ifdef SPRITE_MIRROR_EN
    exp_left = 21'd3314; exp_edge_r = 21'd3300; exp_edge_b = 21'd3594; exp_col0 = 21'd3239;
`else
    exp_left = 21'd9685; exp_edge_r = 21'd9699; exp_edge_b = 21'd9965; exp_col0 = 21'd9600;
`endif
    do_reset();
    moving = 1'b1; tick = 1'b1;
    step(); step(); step();
    tick = 1'b0;
    checks++; if (pp_frame !== 4'd2) begin errors++; $display("FAIL addr_setup_frame got=%0d exp=2", pp_frame); end
    dir = 1'b0; draw_x = 10'd0; draw_y = 10'd0;
    step();
    player_x = 10'd100; player_y = 10'd50; draw_x = 10'd105; draw_y = 10'd52;
    step();
    checks++; if (pp_on !== 1'b1) begin errors++; $display("FAIL addr_right_on got=%0b exp=1", pp_on); end
    checks++; if (pp_addr !== 21'd3285) begin errors++; $display("FAIL addr_right got=%0d exp=3285", pp_addr); end
    dir = 1'b1;
    step();
    checks++; if (pp_addr !== 21'd3285) begin errors++; $display("FAIL addr_tear_free got=%0d exp=3285", pp_addr); end
    draw_x = 10'd0; draw_y = 10'd0;
    step();
    draw_x = 10'd105; draw_y = 10'd52;
    step();
    checks++; if (pp_addr !== exp_left) begin errors++; $display("FAIL addr_left got=%0d exp=%0d", pp_addr, exp_left); end
    draw_x = 10'd100; draw_y = 10'd50;
    step();
    checks++; if (pp_addr !== exp_col0) begin errors++; $display("FAIL addr_left_col0 got=%0d exp=%0d", pp_addr, exp_col0); end
    player_x = 10'd620; draw_x = 10'd639; draw_y = 10'd52;
    step();
    checks++; if (pp_on !== 1'b1) begin errors++; $display("FAIL edge_right_on got=%0b exp=1", pp_on); end
    checks++; if (pp_addr !== exp_edge_r) begin errors++; $display("FAIL edge_right_addr got=%0d exp=%0d", pp_addr, exp_edge_r); end
    player_x = 10'd100; player_y = 10'd470; draw_x = 10'd105; draw_y = 10'd479;
    step();
    checks++; if (pp_on !== 1'b1) begin errors++; $display("FAIL edge_bottom_on got=%0b exp=1", pp_on); end
    checks++; if (pp_addr !== exp_edge_b) begin errors++; $display("FAIL edge_bottom_addr got=%0d exp=%0d", pp_addr, exp_edge_b); end
    player_y = 10'd50; draw_x = 10'd99; draw_y = 10'd52;
    step();
    checks++; if (pp_on !== 1'b0) begin errors++; $display("FAIL left_of_window_on got=%0b exp=0", pp_on); end
    checks++; if (pp_addr !== 21'd0) begin errors++; $display("FAIL left_of_window_addr got=%0d exp=0", pp_addr); end
    draw_x = 10'd140;
    step();
    checks++; if (pp_on !== 1'b0) begin errors++; $display("FAIL right_of_window_on got=%0b exp=0", pp_on); end
    draw_x = 10'd139; draw_y = 10'd89;
    step();
    checks++; if (pp_on !== 1'b1) begin errors++; $display("FAIL last_pixel_on got=%0b exp=1", pp_on); end
    draw_y = 10'd90;
    step();
    checks++; if (pp_on !== 1'b0) begin errors++; $display("FAIL below_window_on got=%0b exp=0", pp_on); end
  endtask

  initial begin
    test_reset();
    test_pingpong();
    test_loop_hold();
    test_oneshot();
    test_window_addr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
